reg_bank: RTL and testbench

//  Parametrised multi-entry successor to the single 16-bit load-enable register.

---
 rtl/reg_bank_pkg.sv | 12 +
 rtl/reg_bank_cell.sv | 31 +++
 rtl/reg_bank.sv | 117 +++++++++++
 tb/tb_reg_bank.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the reg_bank register file.
package reg_bank_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;

    // Bits needed to hold an occupancy value from 0 up to and including depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_bank_cell.sv
// One storage entry of reg_bank: data register plus valid flag.
// Clear has priority over load; rst is asynchronous and active-high.
module reg_cell
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank.sv
// Multi-entry register bank: one write port, two registered read ports, valid tracking.
// Optional build macro REG_BANK_BYPASS_EN enables write-through forwarding on both read ports.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int  WIDTH = DEF_WIDTH,
    parameter int  DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rin,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] Datain,
    input  logic             clr,
    input  logic             ren_a,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] Dataout_a,
    output logic             valid_a,
    input  logic             ren_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] Dataout_b,
    output logic             valid_b,
    output logic [CW-1:0]    count,
    output logic             full
);

    // The address space is padded to a power of two; slots past DEPTH read as zero/invalid
    // and never decode a write, which handles out-of-range addresses without compares.
    localparam int SLOTS = 2 ** AW;

    logic [WIDTH-1:0] q_pad [SLOTS];
    logic [SLOTS-1:0] v_pad;
    logic [SLOTS-1:0] ld_pad;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        if (i < DEPTH) begin : g_cell
            assign ld_pad[i] = rin && (waddr == AW'(i));
            reg_cell #(.WIDTH(WIDTH)) u_cell (
                .clk   (clk),
                .rst   (rst),
                .load  (ld_pad[i]),
                .clear (clr),
                .d     (Datain),
                .q     (q_pad[i]),
                .valid (v_pad[i])
            );
        end else begin : g_pad
            assign ld_pad[i] = 1'b0;
            assign q_pad[i]  = '0;
            assign v_pad[i]  = 1'b0;
        end
    end

    logic [WIDTH-1:0] rd_a, rd_b;
    logic             rv_a, rv_b;

    // NOTE: each always_comb output is given a value first on every path, so no latch is inferred.
    always_comb begin
        rd_a = q_pad[raddr_a];
        rv_a = v_pad[raddr_a];
        rd_b = q_pad[raddr_b];
        rv_b = v_pad[raddr_b];
`ifdef REG_BANK_BYPASS_EN
        if (clr) begin
            rd_a = '0;
            rv_a = 1'b0;
        end else if (ld_pad[raddr_a]) begin
            rd_a = Datain;
            rv_a = 1'b1;
        end
        if (clr) begin
            rd_b = '0;
            rv_b = 1'b0;
        end else if (ld_pad[raddr_b]) begin
            rd_b = Datain;
            rv_b = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Dataout_a <= '0;
            valid_a   <= 1'b0;
            Dataout_b <= '0;
            valid_b   <= 1'b0;
        end else begin
            if (ren_a) begin
                Dataout_a <= rd_a;
                valid_a   <= rv_a;
            end
            if (ren_b) begin
                Dataout_b <= rd_b;
                valid_b   <= rv_b;
            end
        end
    end

    // Occupancy only rises when an in-range write lands on an invalid entry, so it caps at DEPTH.
    logic wr_new;
    assign wr_new = |(ld_pad & ~v_pad);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (wr_new) begin
            count <= count + CW'(1);
        end
    end

    assign full = (count == CW'(DEPTH));

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: a DEPTH=8 and a DEPTH=6 instance share stimulus and are
// compared against an array-based model of the register-bank rules.
module tb_reg_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rin = 1'b0;
    logic        clr = 1'b0;
    logic        ren_a = 1'b0;
    logic        ren_b = 1'b0;
    logic [2:0]  waddr = '0;
    logic [2:0]  raddr_a = '0;
    logic [2:0]  raddr_b = '0;
    logic [15:0] din = '0;

    logic [15:0] da8, db8, da6, db6;
    logic        va8, vb8, va6, vb6, full8, full6;
    logic [3:0]  cnt8;
    logic [2:0]  cnt6;

    int passed = 0;
    int total  = 0;

    int          dep [2] = '{8, 6};
    logic [15:0] mem [2][8];
    bit          val [2][8];
    logic [15:0] eda [2];
    logic [15:0] edb [2];
    bit          eva [2];
    bit          evb [2];

    always #10 clk = ~clk;

    reg_bank #(.WIDTH(16), .DEPTH(8)) dut8 (
        .clk(clk), .rst(rst), .rin(rin), .waddr(waddr), .Datain(din), .clr(clr),
        .ren_a(ren_a), .raddr_a(raddr_a), .Dataout_a(da8), .valid_a(va8),
        .ren_b(ren_b), .raddr_b(raddr_b), .Dataout_b(db8), .valid_b(vb8),
        .count(cnt8), .full(full8)
    );

    reg_bank #(.WIDTH(16), .DEPTH(6)) dut6 (
        .clk(clk), .rst(rst), .rin(rin), .waddr(waddr), .Datain(din), .clr(clr),
        .ren_a(ren_a), .raddr_a(raddr_a), .Dataout_a(da6), .valid_a(va6),
        .ren_b(ren_b), .raddr_b(raddr_b), .Dataout_b(db6), .valid_b(vb6),
        .count(cnt6), .full(full6)
    );

    // What a read of address ra returns at the coming edge, as {valid, data}.
    function automatic logic [16:0] model_read(input int k, input logic [2:0] ra);
        if (int'(ra) >= dep[k]) return 17'd0;
`ifdef REG_BANK_BYPASS_EN
        if (clr) return 17'd0;
        if (rin && waddr == ra) return {1'b1, din};
`endif
        return {val[k][ra], mem[k][ra]};
    endfunction

    function automatic int model_count(input int k);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(val[k][i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                mem[k][i] = '0;
                val[k][i] = 1'b0;
            end
            eda[k] = '0; edb[k] = '0; eva[k] = 1'b0; evb[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [16:0] ra, rb;
        for (int k = 0; k < 2; k++) begin
            ra = model_read(k, raddr_a);
            rb = model_read(k, raddr_b);
            if (ren_a) begin eva[k] = ra[16]; eda[k] = ra[15:0]; end
            if (ren_b) begin evb[k] = rb[16]; edb[k] = rb[15:0]; end
            if (clr) begin
                for (int i = 0; i < 8; i++) begin
                    mem[k][i] = '0;
                    val[k][i] = 1'b0;
                end
            end else if (rin && int'(waddr) < dep[k]) begin
                mem[k][waddr] = din;
                val[k][waddr] = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string step);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s d%0d Dataout_a", step, dep[k]), 32'(k == 0 ? da8 : da6), 32'(eda[k]));
            check($sformatf("%s d%0d valid_a", step, dep[k]), 32'(k == 0 ? va8 : va6), 32'(eva[k]));
            check($sformatf("%s d%0d Dataout_b", step, dep[k]), 32'(k == 0 ? db8 : db6), 32'(edb[k]));
            check($sformatf("%s d%0d valid_b", step, dep[k]), 32'(k == 0 ? vb8 : vb6), 32'(evb[k]));
            check($sformatf("%s d%0d count", step, dep[k]),
                  (k == 0) ? 32'(cnt8) : 32'(cnt6), 32'(model_count(k)));
            check($sformatf("%s d%0d full", step, dep[k]), 32'(k == 0 ? full8 : full6),
                  32'(model_count(k) == dep[k]));
        end
    endtask

    task automatic cycle(input string step);
        model_edge();
        @(posedge clk);
        #1;
        check_all(step);
    endtask

    task automatic pulse_reset(input string step);
        rst = 1'b1;
        #2;
        model_reset();
        check_all(step);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        // Reset held across an edge with a write pending: nothing may be stored.
        rin = 1'b1; waddr = 3'd2; din = 16'h0055;
        #15;
        model_reset();
        check_all("reset");
        rst = 1'b0;
        rin = 1'b0; ren_a = 1'b1; raddr_a = 3'd2;
        cycle("reset_read");

        rin = 1'b1; waddr = 3'd3; din = 16'd20; ren_a = 1'b0;
        cycle("write3");
        rin = 1'b0; ren_a = 1'b1; raddr_a = 3'd3;
        cycle("read3");

        ren_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rin = 1'b1; waddr = 3'(i); din = 16'hFFFF;
            cycle("fill");
        end
        waddr = 3'd0; din = 16'h0000;
        cycle("rewrite0");
        rin = 1'b0; ren_b = 1'b1; raddr_b = 3'd0;
        cycle("read0_b");

        // clr and a write in the same edge on a full bank.
        clr = 1'b1; rin = 1'b1; waddr = 3'd5; din = 16'h1234; ren_b = 1'b0;
        cycle("clr_rin");
        clr = 1'b0; rin = 1'b0; ren_a = 1'b1; raddr_a = 3'd5;
        cycle("read_after_clr");

        rin = 1'b1; waddr = 3'd5; din = 16'hABCD; ren_a = 1'b1; raddr_a = 3'd5;
        cycle("raw_same_cycle");
        rin = 1'b0;
        cycle("read_after_raw");

        // Port A held while its entry changes; port B probes addr 7 (out of range when DEPTH=6).
        ren_a = 1'b0; rin = 1'b1; waddr = 3'd5; din = 16'h5A5A;
        ren_b = 1'b1; raddr_b = 3'd7;
        cycle("hold_a");
        rin = 1'b1; waddr = 3'd7; din = 16'h7777; ren_b = 1'b0;
        cycle("write7");
        rin = 1'b0; ren_b = 1'b1; raddr_b = 3'd7;
        cycle("read7");

        rin = 1'b1; waddr = 3'd1; din = 16'h0F0F; clr = 1'b1; ren_a = 1'b1; raddr_a = 3'd1;
        cycle("read_during_clr");
        clr = 1'b0;
        cycle("post_clr");

        for (int i = 0; i < 400; i++) begin
            rin     = ($urandom_range(0, 3) != 0);
            waddr   = 3'($urandom_range(0, 7));
            din     = 16'($urandom);
            clr     = ($urandom_range(0, 39) == 0);
            ren_a   = ($urandom_range(0, 3) != 0);
            raddr_a = 3'($urandom_range(0, 7));
            ren_b   = ($urandom_range(0, 3) != 0);
            raddr_b = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) pulse_reset("rnd_reset");
            else cycle("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
